// File: rtl/bcd_convert_arbiter_if.sv
// Request/result bundle for bcd_convert_arbiter. conv_count exists only when
// BCD_ARB_CONV_CNT_EN is defined.
interface bcd_convert_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int REQ_ID_WIDTH = 2,
  parameter int BIN_WIDTH    = 12,
  parameter int DIGITS       = 4
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*BIN_WIDTH-1:0] req_binary;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         bcd_valid;
  logic                         bcd_ready;
  logic [DIGITS*4-1:0]          bcd_digits;
  logic [REQ_ID_WIDTH-1:0]      bcd_req_id;
  logic                         busy;
`ifdef BCD_ARB_CONV_CNT_EN
  logic [15:0]                  conv_count;
`endif

  modport slave (
    input  req_valid, req_binary, bcd_ready,
`ifdef BCD_ARB_CONV_CNT_EN
    output conv_count,
`endif
    output req_ready, bcd_valid, bcd_digits, bcd_req_id, busy
  );

  modport master (
    output req_valid, req_binary, bcd_ready,
`ifdef BCD_ARB_CONV_CNT_EN
    input  conv_count,
`endif
    input  req_ready, bcd_valid, bcd_digits, bcd_req_id, busy
  );
endinterface

// File: rtl/bcd_convert_arbiter.sv
// Round-robin shared 1-bit/cycle double-dabble binary-to-BCD converter.
// Optional feature macro: BCD_ARB_CONV_CNT_EN (adds 16-bit completed-conversion counter).
module bcd_convert_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int REQ_ID_WIDTH = 2,
  parameter int BIN_WIDTH    = 12,
  parameter int DIGITS       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  bcd_convert_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int DW    = DIGITS * 4;
  localparam int WW    = DW + BIN_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [BIN_WIDTH-1:0]    operand_q, operand_d;
  logic [DW-1:0]           digits_q, digits_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [REQ_ID_WIDTH-1:0] id_q, id_d;
  logic [REQ_ID_WIDTH-1:0] ptr_q, ptr_d;

  logic [NUM_REQ-1:0]      grant_s;
  logic [REQ_ID_WIDTH-1:0] grant_id_s;
  logic [BIN_WIDTH-1:0]    grant_operand_s;
  logic                    grant_found_s;
  logic                    result_taken_s;
  logic [WW-1:0]           shifted_s;

  function automatic logic [DW-1:0] dabble_adjust(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    for (int k = 0; k < DIGITS; k++) begin
      if (d[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = d[4*k +: 4] + 4'd3;
      end else begin
        r[4*k +: 4] = d[4*k +: 4];
      end
    end
    return r;
  endfunction

  function automatic int rr_index(input logic [REQ_ID_WIDTH-1:0] p, input int k);
    return (int'(p) + k) % NUM_REQ;
  endfunction

  // Round-robin search starting just after the last granted requester
  always_comb begin
    grant_s         = '0;
    grant_id_s      = '0;
    grant_operand_s = '0;
    grant_found_s   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant_found_s && bus.req_valid[rr_index(ptr_q, k)]) begin
        grant_found_s                   = 1'b1;
        grant_s[rr_index(ptr_q, k)]     = 1'b1;
        grant_id_s                      = REQ_ID_WIDTH'(rr_index(ptr_q, k));
        grant_operand_s                 = bus.req_binary[rr_index(ptr_q, k)*BIN_WIDTH +: BIN_WIDTH];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  assign result_taken_s = (state_q == S_DONE) && bus.bcd_ready;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found_s) begin
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        if (bus.bcd_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; grants are suppressed during reset and outside IDLE
  always_comb begin
    if ((state_q == S_IDLE) && !reset) begin
      bus.req_ready = grant_s;
    end else begin
      bus.req_ready = '0;
    end
    bus.busy       = (state_q != S_IDLE);
    bus.bcd_valid  = (state_q == S_DONE);
    bus.bcd_digits = digits_q;
    bus.bcd_req_id = id_q;
  end

  // One double-dabble step: adjust digits, then shift {digits, operand} left
  always_comb begin
    shifted_s = {dabble_adjust(digits_q), operand_q} << 1;
  end

  // Datapath next values
  always_comb begin
    operand_d = operand_q;
    digits_d  = digits_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found_s) begin
          operand_d = grant_operand_s;
          digits_d  = '0;
          cnt_d     = CNT_W'(BIN_WIDTH);
          id_d      = grant_id_s;
          ptr_d     = grant_id_s;
        end else begin
          operand_d = operand_q;
        end
      end
      S_SHIFT: begin
        digits_d  = shifted_s[WW-1 -: DW];
        operand_d = shifted_s[BIN_WIDTH-1:0];
        cnt_d     = cnt_q - CNT_W'(1);
      end
      S_DONE:  digits_d = digits_q;
      default: digits_d = digits_q;
    endcase
  end

  // Datapath registers; pointer resets so requester 0 is searched first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      operand_q <= '0;
      digits_q  <= '0;
      cnt_q     <= '0;
      id_q      <= '0;
      ptr_q     <= REQ_ID_WIDTH'(NUM_REQ - 1);
    end else begin
      operand_q <= operand_d;
      digits_q  <= digits_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
    end
  end

`ifdef BCD_ARB_CONV_CNT_EN
  logic [15:0] conv_count_q;

  // Completed-conversion counter, wraps naturally at 16 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conv_count_q <= 16'h0000;
    end else if (result_taken_s) begin
      conv_count_q <= conv_count_q + 16'h0001;
    end else begin
      conv_count_q <= conv_count_q;
    end
  end

  assign bus.conv_count = conv_count_q;
`else
  logic unused_result_taken_s;
  assign unused_result_taken_s = result_taken_s;
`endif

endmodule
